tdoa_xcorr: RTL and testbench

TDOA_XCORR -- requirements
Module: tdoa_xcorr

---
 rtl/tdoa_pkg.sv | 19 +
 rtl/tdoa_delay_line.sv | 44 ++++
 rtl/tdoa_xcorr.sv | 223 ++++++++++++++++++++++
 tb/tb_tdoa_xcorr.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdoa_pkg.sv
// Shared types and widths for the two-microphone TDOA cross-correlator.
package tdoa_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        SEARCH = 2'd2,
        REPORT = 2'd3
    } tdoa_state_t;

    // Distance of accumulator index j from the zero-lag index, i.e. |d|.
    function automatic int lag_dist(input int j, input int max_lag);
        return (j > max_lag) ? (j - max_lag) : (max_lag - j);
    endfunction

endpackage

// File: rtl/tdoa_delay_line.sv
// Sample delay line: shifts a new sample in at tap 0 on shift_en, tap i holds
// the sample from i shifts ago. One tap is read out by index.
module tdoa_delay_line
    import tdoa_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       shift_en,
    input  logic signed [SAMPLE_W-1:0] din,
    input  logic        [IDX_W-1:0]    rd_idx,
    output logic signed [SAMPLE_W-1:0] rd_data
);

    logic signed [SAMPLE_W-1:0] tap_q [DEPTH];
    logic signed [SAMPLE_W-1:0] tap_d [DEPTH];

    // Next tap contents: hold, or shift by one with din entering tap 0.
    always_comb begin
        tap_d = tap_q;
        if (shift_en) begin
            tap_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                tap_d[i] = tap_q[i-1];
            end
        end
    end

    // Tap registers, cleared only by reset (history survives across windows).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            tap_q <= tap_d;
        end
    end

    assign rd_data = tap_q[rd_idx];

endmodule

// File: rtl/tdoa_xcorr.sv
// Time-difference-of-arrival estimator: cross-correlates left/right mic
// samples over MAX_LAG lags each way for WIN_LEN pairs and reports the best lag.
// Optional build macro TDOA_CONF_GATE_EN: suppress reports whose peak is not
// above MIN_PEAK (outputs then hold their previous values).
//
// state  | meaning
// IDLE   | wait for a complete left/right pair, shift it into the delay lines
// MAC    | one multiply-accumulate per cycle over all 2*MAX_LAG+1 lags
// SEARCH | scan accumulators for the best lag, clearing each one as it is read
// REPORT | lag_out/peak_out/lag_valid presented for one cycle
module tdoa_xcorr
    import tdoa_pkg::*;
#(
    parameter int MAX_LAG  = 8,
    parameter int WIN_LEN  = 1024,
    parameter int ACC_W    = 48,
    parameter int MIN_PEAK = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic signed [SAMPLE_W-1:0]        left_sample,
    input  logic                              left_valid,
    input  logic signed [SAMPLE_W-1:0]        right_sample,
    input  logic                              right_valid,
    output logic signed [$clog2(MAX_LAG)+1:0] lag_out,
    output logic signed [ACC_W-1:0]           peak_out,
    output logic                              lag_valid,
    output logic                              overrun
);

    localparam int NTAP   = 2*MAX_LAG + 1;
    localparam int LAG_W  = $clog2(MAX_LAG) + 2;
    localparam int J_W    = $clog2(NTAP);
    localparam int LIDX_W = $clog2(MAX_LAG + 1);
    localparam int CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [J_W-1:0] J_LAST = J_W'(NTAP - 1);
`ifdef TDOA_CONF_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    tdoa_state_t                state_q, state_d;
    logic                       pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic signed [SAMPLE_W-1:0] samp_l_q, samp_l_d, samp_r_q, samp_r_d;
    logic                       overrun_q, overrun_d;
    logic        [J_W-1:0]      j_q, j_d;
    logic        [CNT_W-1:0]    pair_cnt_q, pair_cnt_d;
    logic signed [ACC_W-1:0]    acc_q [NTAP];
    logic signed [ACC_W-1:0]    acc_d [NTAP];
    logic signed [ACC_W-1:0]    best_val_q, best_val_d;
    logic        [J_W-1:0]      best_j_q, best_j_d;
    logic signed [LAG_W-1:0]    lag_out_q, lag_out_d;
    logic signed [ACC_W-1:0]    peak_q, peak_d;
    logic                       lag_valid_q, lag_valid_d;

    logic                       pair_take;
    logic signed [SAMPLE_W-1:0] l_tap, r_tap;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    cur_val, fin_val;
    logic        [J_W-1:0]      fin_j;
    logic                       cand_wins, report_ok;
    int                         dist_cur, dist_best;

    // Left line only needs L[n-MAX_LAG]; right line is read at R[n-j].
    tdoa_delay_line #(.DEPTH(MAX_LAG + 1)) u_left_dl (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (pair_take),
        .din      (samp_l_q),
        .rd_idx   (LIDX_W'(MAX_LAG)),
        .rd_data  (l_tap)
    );

    tdoa_delay_line #(.DEPTH(NTAP)) u_right_dl (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (pair_take),
        .din      (samp_r_q),
        .rd_idx   (j_q),
        .rd_data  (r_tap)
    );

    assign prod      = PROD_W'(l_tap) * PROD_W'(r_tap);
    assign dist_cur  = lag_dist(int'(j_q), MAX_LAG);
    assign dist_best = lag_dist(int'(best_j_q), MAX_LAG);

    // Pending sample capture; a strobe landing on a full, unconsumed pending flags overrun.
    always_comb begin
        pair_take = (state_q == IDLE) && pend_l_q && pend_r_q;
        pend_l_d  = pend_l_q && !pair_take;
        pend_r_d  = pend_r_q && !pair_take;
        samp_l_d  = samp_l_q;
        samp_r_d  = samp_r_q;
        overrun_d = overrun_q;
        if (left_valid) begin
            if (pend_l_q && !pair_take) overrun_d = 1'b1;
            pend_l_d = 1'b1;
            samp_l_d = left_sample;
        end
        if (right_valid) begin
            if (pend_r_q && !pair_take) overrun_d = 1'b1;
            pend_r_d = 1'b1;
            samp_r_d = right_sample;
        end
    end

    // Best-so-far compare: larger value, then smaller |d|, then positive d (smaller j).
    always_comb begin
        cur_val   = acc_q[j_q];
        cand_wins = 1'b0;
        if (j_q == J_LAST) begin
            cand_wins = 1'b1;
        end else if (cur_val > best_val_q) begin
            cand_wins = 1'b1;
        end else if (cur_val == best_val_q) begin
            if (dist_cur < dist_best) begin
                cand_wins = 1'b1;
            end else if ((dist_cur == dist_best) && (j_q < best_j_q)) begin
                cand_wins = 1'b1;
            end
        end
        fin_val   = cand_wins ? cur_val : best_val_q;
        fin_j     = cand_wins ? j_q : best_j_q;
        report_ok = !GATE_EN || (fin_val > ACC_W'(MIN_PEAK));
    end

    // FSM next state; j counts down 2*MAX_LAG..0 in both MAC and SEARCH.
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        pair_cnt_d  = pair_cnt_q;
        acc_d       = acc_q;
        best_val_d  = best_val_q;
        best_j_d    = best_j_q;
        lag_out_d   = lag_out_q;
        peak_d      = peak_q;
        lag_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pair_take) begin
                    state_d = MAC;
                    j_d     = J_LAST;
                end
            end
            MAC: begin
                acc_d[j_q] = acc_q[j_q] + ACC_W'(prod);
                if (j_q == '0) begin
                    if (pair_cnt_q == CNT_W'(WIN_LEN - 1)) begin
                        pair_cnt_d = '0;
                        state_d    = SEARCH;
                        j_d        = J_LAST;
                    end else begin
                        pair_cnt_d = pair_cnt_q + CNT_W'(1);
                        state_d    = IDLE;
                    end
                end else begin
                    j_d = j_q - J_W'(1);
                end
            end
            SEARCH: begin
                acc_d[j_q] = '0;
                best_val_d = fin_val;
                best_j_d   = fin_j;
                if (j_q == '0) begin
                    state_d = REPORT;
                    if (report_ok) begin
                        lag_out_d   = LAG_W'(MAX_LAG) - LAG_W'(fin_j);
                        peak_d      = fin_val;
                        lag_valid_d = 1'b1;
                    end
                end else begin
                    j_d = j_q - J_W'(1);
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_l_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            samp_l_q    <= '0;
            samp_r_q    <= '0;
            overrun_q   <= 1'b0;
            j_q         <= '0;
            pair_cnt_q  <= '0;
            for (int i = 0; i < NTAP; i++) begin
                acc_q[i] <= '0;
            end
            best_val_q  <= '0;
            best_j_q    <= '0;
            lag_out_q   <= '0;
            peak_q      <= '0;
            lag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            samp_l_q    <= samp_l_d;
            samp_r_q    <= samp_r_d;
            overrun_q   <= overrun_d;
            j_q         <= j_d;
            pair_cnt_q  <= pair_cnt_d;
            acc_q       <= acc_d;
            best_val_q  <= best_val_d;
            best_j_q    <= best_j_d;
            lag_out_q   <= lag_out_d;
            peak_q      <= peak_d;
            lag_valid_q <= lag_valid_d;
        end
    end

    assign lag_out   = lag_out_q;
    assign peak_out  = peak_q;
    assign lag_valid = lag_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdoa_xcorr.sv
// Scoreboard bench for tdoa_xcorr (MAX_LAG=4, WIN_LEN=16, MIN_PEAK=0).
module tb_tdoa_xcorr;

    localparam int MAX_LAG  = 4;
    localparam int WIN_LEN  = 16;
    localparam int ACC_W    = 48;
    localparam int MIN_PEAK = 0;
    localparam int LAG_W    = $clog2(MAX_LAG) + 2;

    localparam int M_NORM  = 0;
    localparam int M_SPLIT = 1;
    localparam int M_OVR   = 2;
    localparam int M_RST   = 3;

`ifdef TDOA_CONF_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic signed [15:0]      left_sample = '0;
    logic                    left_valid = 1'b0;
    logic signed [15:0]      right_sample = '0;
    logic                    right_valid = 1'b0;
    logic signed [LAG_W-1:0] lag_out;
    logic signed [ACC_W-1:0] peak_out;
    logic                    lag_valid;
    logic                    overrun;

    tdoa_xcorr #(
        .MAX_LAG  (MAX_LAG),
        .WIN_LEN  (WIN_LEN),
        .ACC_W    (ACC_W),
        .MIN_PEAK (MIN_PEAK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .left_sample  (left_sample),
        .left_valid   (left_valid),
        .right_sample (right_sample),
        .right_valid  (right_valid),
        .lag_out      (lag_out),
        .peak_out     (peak_out),
        .lag_valid    (lag_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     lag;
        longint peak;
        int     cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic signed [15:0] wl [WIN_LEN];
    logic signed [15:0] wr [WIN_LEN];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_win();
        for (int i = 0; i < WIN_LEN; i++) begin
            wl[i] = '0;
            wr[i] = '0;
        end
    endtask

    // Feeds one window of pairs 12 cycles apart. With the DUT idle when a pair's
    // strobes are sampled, lag_valid for the window's last pair lands 20 cycles
    // after the drive cycle (1 IDLE + 9 MAC + 9 SEARCH + REPORT).
    task automatic send_window(input int mode, input bit want, input int exp_lag,
                               input longint exp_peak);
        int k_last;
        int off;
        k_last = 0;
        off    = 20;
        for (int p = 0; p < WIN_LEN; p++) begin
            @(posedge clk); #1;
            if (mode == M_OVR && p == 3) begin
                left_sample = 16'sd7777;
                left_valid  = 1'b1;
                @(posedge clk); #1;
                left_sample = wl[p];
                @(posedge clk); #1;
                left_valid   = 1'b0;
                right_sample = wr[p];
                right_valid  = 1'b1;
                @(posedge clk); #1;
                right_valid = 1'b0;
                repeat (10) @(posedge clk);
            end else if (mode == M_SPLIT && p == WIN_LEN - 2) begin
                // Pair 14 normally, then pair 15 split across two cycles inside pair 14's MAC.
                left_sample  = wl[p];
                right_sample = wr[p];
                left_valid   = 1'b1;
                right_valid  = 1'b1;
                k_last       = cyc;
                @(posedge clk); #1;
                left_valid  = 1'b0;
                right_valid = 1'b0;
                repeat (2) @(posedge clk); #1;
                left_sample = wl[p+1];
                left_valid  = 1'b1;
                @(posedge clk); #1;
                left_valid   = 1'b0;
                right_sample = wr[p+1];
                right_valid  = 1'b1;
                @(posedge clk); #1;
                right_valid = 1'b0;
                repeat (6) @(posedge clk);
                off = 30;
                break;
            end else begin
                left_sample  = wl[p];
                right_sample = wr[p];
                left_valid   = 1'b1;
                right_valid  = 1'b1;
                k_last       = cyc;
                @(posedge clk); #1;
                left_valid  = 1'b0;
                right_valid = 1'b0;
                repeat (10) @(posedge clk);
            end
        end
        if (mode == M_RST) begin
            // Land inside the SEARCH phase of this window.
            repeat (3) @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            check("rst_search_lag_out", lag_out, 0);
            check("rst_search_peak_out", peak_out, 0);
            check("rst_search_lag_valid", lag_valid, 0);
            check("rst_search_overrun", overrun, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (30) @(posedge clk);
        end else begin
            if (want) exp_q.push_back('{exp_lag, exp_peak, k_last + off});
            repeat (25) @(posedge clk);
        end
    endtask

    // Monitor: every lag_valid pops one expectation and compares value and timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (lag_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lag_valid: got lag_valid=1 lag=%0d peak=%0d at cycle %0d, expected no report",
                             lag_out, peak_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("lag_out", lag_out, e.lag);
                    check("peak_out", peak_out, e.peak);
                    check("lag_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_lag_out", lag_out, 0);
        check("reset_peak_out", peak_out, 0);
        check("reset_lag_valid", lag_valid, 0);
        check("reset_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Impulses: right lags left by two pairs.
        clear_win();
        wl[5] = 16'sd1000;
        wr[7] = 16'sd1000;
        send_window(M_NORM, 1'b1, 2, 64'sd1000000);
        check("overrun_clean", overrun, 0);

        // Identical short ramps; last pair arrives split during the previous MAC.
        clear_win();
        for (int i = 0; i < 5; i++) begin
            wl[2+i] = 16'(100 * (i + 1));
            wr[2+i] = 16'(100 * (i + 1));
        end
        send_window(M_SPLIT, 1'b1, 0, 64'sd550000);

        // All-zero window: every lag ties at 0, zero lag wins.
        clear_win();
        send_window(M_NORM, !GATED, 0, 64'sd0);
        check("overrun_after_split", overrun, 0);

        // Two left strobes before the right one: second left value is used.
        clear_win();
        wl[3] = 16'sd300;
        wr[3] = 16'sd300;
        send_window(M_OVR, 1'b1, 0, 64'sd90000);
        check("overrun_set", overrun, 1);

        // Reset during SEARCH discards the window.
        clear_win();
        wl[2] = 16'sd900;
        wr[4] = 16'sd900;
        check("overrun_held", overrun, 1);
        send_window(M_RST, 1'b0, 0, 64'sd0);

        // Negative samples, most negative lag.
        clear_win();
        wl[8] = -16'sd500;
        wr[4] = -16'sd500;
        send_window(M_NORM, 1'b1, -4, 64'sd250000);

        // Equal peaks at d=-1 and d=+1: positive lag wins.
        clear_win();
        wl[6] = 16'sd100;
        wr[5] = 16'sd100;
        wr[7] = 16'sd100;
        send_window(M_NORM, 1'b1, 1, 64'sd10000);

        // Only a negative product: best is a zero lag nearest centre, d=+1.
        clear_win();
        wl[6] = 16'sd200;
        wr[6] = -16'sd300;
        send_window(M_NORM, !GATED, 1, 64'sd0);

        // Most positive lag.
        clear_win();
        wl[3] = 16'sd50;
        wr[7] = 16'sd70;
        send_window(M_NORM, 1'b1, 4, 64'sd3500);

        repeat (10) @(posedge clk);
        check("reports_outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
